// File: rtl/rs_pkg.sv
// Shared types for the reservation station.
//   t_rob_id      : ROB entry identifier carried on dispatch and writeback
//   t_uinstr_disp : dispatched uinstr with its robid and two source dependencies
//   t_rs_entry    : one station slot (valid, per-source ready bits, payload)
//   wb_hit()      : writeback broadcast matches a source robid
package rs_pkg;

  localparam int ROB_ID_W = 6;
  localparam int UINSTR_W = 16;

  typedef logic [ROB_ID_W-1:0] t_rob_id;

  typedef struct packed {
    logic [UINSTR_W-1:0] uinstr;
    t_rob_id             robid;
    logic                src1_rob_pdg;
    t_rob_id             src1_robid;
    logic                src2_rob_pdg;
    t_rob_id             src2_robid;
  } t_uinstr_disp;

  typedef struct packed {
    logic         valid;
    logic         src1_rdy;
    logic         src2_rdy;
    t_uinstr_disp payload;
  } t_rs_entry;

  function automatic logic wb_hit(input logic wb_valid, input t_rob_id wb_robid,
                                  input t_rob_id src_robid);
    return wb_valid && (wb_robid == src_robid);
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for oldest-first select.
//   clk, reset  : clock, async active-low reset
//   alloc       : one-hot slot being written this edge
//   dealloc     : one-hot slot being freed this edge
//   req         : slots eligible for select
//   gnt         : one-hot oldest requesting slot
// older_q[i][j] = 1 means slot i is older than slot j.
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] alloc,
  input  logic [NUM_ENTRIES-1:0] dealloc,
  input  logic [NUM_ENTRIES-1:0] req,
  output logic [NUM_ENTRIES-1:0] gnt
);

  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] blocked;

  // A new arrival is older than nobody (its row is rewritten) and every other
  // slot is marked older than it (its column is set). Bits left over from free
  // slots are harmless: they are overwritten when that slot is allocated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (alloc[i])        older_q[i][j] <= 1'b0;
          else if (alloc[j])   older_q[i][j] <= 1'b1;
          else if (dealloc[j]) older_q[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (req[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  assign gnt = req & ~blocked;

endmodule

// File: rtl/rs.sv
// Reservation station: receives alloc dispatch, wakes sources on ROB writeback,
// issues the oldest ready entry to its execution unit.
//   clk, reset       : clock, async active-low reset
//   flush            : drop all entries at the edge, suppress issue this cycle
//   disp_valid_rs1   : dispatch valid; disp_rs1 : dispatched uinstr
//   rs_stall_rs0     : alloc must not dispatch next cycle
//   wb_valid/wb_robid: ROB writeback broadcast
//   ex_stall_rs2     : execution unit cannot accept this cycle
//   issue_valid_rs2  : issue request; issue_rs2 : selected entry (pdg bits 0)
// Build option RS_WB_BYPASS_EN: a broadcast completing an entry's last pending
// source makes it select-eligible in the same cycle. Without it, eligibility
// comes only from flopped ready bits and wb_* has no path to issue_*.
module rs
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         disp_valid_rs1,
  input  t_uinstr_disp disp_rs1,
  output logic         rs_stall_rs0,
  input  logic         wb_valid,
  input  t_rob_id      wb_robid,
  input  logic         ex_stall_rs2,
  output logic         issue_valid_rs2,
  output t_uinstr_disp issue_rs2
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  t_rs_entry              ent_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] wake1, wake2, req, gnt;
  logic [NUM_ENTRIES-1:0] free_oh, alloc_oh, dealloc_oh;
  logic [CNT_W-1:0]       num_free;
  logic                   free_found;
  logic                   fire;
  logic [$bits(t_uinstr_disp)-1:0] issue_vec;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake1[i] = wb_hit(wb_valid, wb_robid, ent_q[i].payload.src1_robid);
      wake2[i] = wb_hit(wb_valid, wb_robid, ent_q[i].payload.src2_robid);
`ifdef RS_WB_BYPASS_EN
      req[i] = ent_q[i].valid && (ent_q[i].src1_rdy || wake1[i])
                              && (ent_q[i].src2_rdy || wake2[i]);
`else
      req[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
`endif
    end
  end

  always_comb begin
    free_oh    = '0;
    num_free   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!ent_q[i].valid) begin
        num_free = num_free + CNT_W'(1);
        if (!free_found) begin
          free_oh[i] = 1'b1;
          free_found = 1'b1;
        end
      end
    end
  end

  // A same-cycle fire is deliberately not credited: the freed slot only shows
  // up in num_free once its valid flop has cleared.
  assign rs_stall_rs0 = (num_free == CNT_W'(disp_valid_rs1));

  assign alloc_oh        = free_oh & {NUM_ENTRIES{disp_valid_rs1 && !flush}};
  assign issue_valid_rs2 = (|req) && !flush;
  assign fire            = issue_valid_rs2 && !ex_stall_rs2;
  assign dealloc_oh      = gnt & {NUM_ENTRIES{fire}};

  rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
    .clk     (clk),
    .reset   (reset),
    .alloc   (alloc_oh),
    .dealloc (dealloc_oh),
    .req     (req),
    .gnt     (gnt)
  );

  always_comb begin
    issue_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (gnt[i]) issue_vec = issue_vec | ent_q[i].payload;
    end
    issue_rs2 = flush ? '0 : issue_vec;
    // Issued sources are ready by definition, including a bypassed wakeup.
    issue_rs2.src1_rob_pdg = 1'b0;
    issue_rs2.src2_rob_pdg = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (flush) begin
          ent_q[i].valid <= 1'b0;
        end else if (alloc_oh[i]) begin
          ent_q[i].valid    <= 1'b1;
          ent_q[i].payload  <= disp_rs1;
          // Catch a broadcast arriving together with the dispatch.
          ent_q[i].src1_rdy <= !disp_rs1.src1_rob_pdg ||
                               wb_hit(wb_valid, wb_robid, disp_rs1.src1_robid);
          ent_q[i].src2_rdy <= !disp_rs1.src2_rob_pdg ||
                               wb_hit(wb_valid, wb_robid, disp_rs1.src2_robid);
        end else begin
          if (dealloc_oh[i]) ent_q[i].valid    <= 1'b0;
          if (wake1[i])      ent_q[i].src1_rdy <= 1'b1;
          if (wake2[i])      ent_q[i].src2_rdy <= 1'b1;
        end
      end
    end
  end

  a_no_disp_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(disp_valid_rs1 && num_free == '0));

endmodule

// File: tb/tb_rs.sv
module tb_rs;
  import rs_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         disp_valid = 1'b0;
  t_uinstr_disp disp = '0;
  logic         wb_valid = 1'b0;
  t_rob_id      wb_robid = '0;
  logic         ex_stall = 1'b0;
  logic         rs_stall_rs0;
  logic         issue_valid_rs2;
  t_uinstr_disp issue_rs2;

  always #5 clk = ~clk;

  rs #(.NUM_ENTRIES(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .disp_valid_rs1  (disp_valid),
    .disp_rs1        (disp),
    .rs_stall_rs0    (rs_stall_rs0),
    .wb_valid        (wb_valid),
    .wb_robid        (wb_robid),
    .ex_stall_rs2    (ex_stall),
    .issue_valid_rs2 (issue_valid_rs2),
    .issue_rs2       (issue_rs2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slots with an age stamp; oldest = smallest stamp.
  bit           m_v  [N];
  bit           m_r1 [N];
  bit           m_r2 [N];
  t_uinstr_disp m_p  [N];
  int           m_age[N];
  int           seq = 0;

  function automatic bit hit(input t_rob_id r);
    return wb_valid && (wb_robid == r);
  endfunction

  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < N; i++) begin
      bit e1 = m_r1[i];
      bit e2 = m_r2[i];
`ifdef RS_WB_BYPASS_EN
      e1 = e1 || hit(m_p[i].src1_robid);
      e2 = e2 || hit(m_p[i].src2_robid);
`endif
      if (m_v[i] && e1 && e2 && (best < 0 || m_age[i] < m_age[best])) best = i;
    end
    return best;
  endfunction

  function automatic int m_nfree();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_v[i]) n++;
    return n;
  endfunction

  function automatic t_uinstr_disp clean(input t_uinstr_disp p);
    t_uinstr_disp q = p;
    q.src1_rob_pdg = 1'b0;
    q.src2_rob_pdg = 1'b0;
    return q;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    end else begin
      int s, f;
      s = m_pick();
      f = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_v[i]) f = i;
      if (flush) begin
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_v[i] && hit(m_p[i].src1_robid)) m_r1[i] = 1'b1;
          if (m_v[i] && hit(m_p[i].src2_robid)) m_r2[i] = 1'b1;
        end
        if (s >= 0 && !ex_stall) m_v[s] = 1'b0;
        if (disp_valid && f >= 0) begin
          m_v[f]   = 1'b1;
          m_p[f]   = disp;
          m_r1[f]  = !disp.src1_rob_pdg || hit(disp.src1_robid);
          m_r2[f]  = !disp.src2_rob_pdg || hit(disp.src2_robid);
          m_age[f] = seq;
          seq++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int  s;
    bit  exp_v;
    bit  exp_stall;
    s         = m_pick();
    exp_v     = reset && !flush && (s >= 0);
    exp_stall = reset && ((m_nfree() - int'(disp_valid)) == 0);
    chk("cyc_issue_valid", 64'(issue_valid_rs2), 64'(exp_v));
    chk("cyc_stall", 64'(rs_stall_rs0), 64'(exp_stall));
    if (exp_v)       chk("cyc_issue_payload", 64'(issue_rs2), 64'(clean(m_p[s])));
    else if (!reset) chk("cyc_issue_rs2_reset", 64'(issue_rs2), 64'(0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    flush      = 1'b0;
    wb_valid   = 1'b0;
    ex_stall   = 1'b0;
  endtask

  function automatic t_uinstr_disp mk(input int rid, input bit p1, input int s1,
                                      input bit p2, input int s2);
    t_uinstr_disp d;
    d.uinstr       = UINSTR_W'($urandom);
    d.robid        = t_rob_id'(rid);
    d.src1_rob_pdg = p1;
    d.src1_robid   = t_rob_id'(s1);
    d.src2_rob_pdg = p2;
    d.src2_robid   = t_rob_id'(s2);
    return d;
  endfunction

  task automatic send(input t_uinstr_disp d);
    disp_valid = 1'b1;
    disp       = d;
  endtask

  task automatic expect_issue(input string name, input bit v, input int rid);
    #1;
    chk({name, "_valid"}, 64'(issue_valid_rs2), 64'(v));
    if (v) chk({name, "_robid"}, 64'(issue_rs2.robid), 64'(rid));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit may_disp;
    int rid;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_issue_valid", 64'(issue_valid_rs2), 64'(0));
    chk("reset_stall", 64'(rs_stall_rs0), 64'(0));
    chk("reset_issue_rs2", 64'(issue_rs2), 64'(0));
    reset = 1'b1;
    cyc();

    // 1: three ready uinstrs issue at t+1..t+3 in order
    send(mk(1, 0, 0, 0, 0)); expect_issue("t1_c0", 0, 0); cyc();
    send(mk(2, 0, 0, 0, 0)); expect_issue("t1_c1", 1, 1); cyc();
    send(mk(3, 0, 0, 0, 0)); expect_issue("t1_c2", 1, 2); cyc();
    idle();                  expect_issue("t1_c3", 1, 3); cyc();
    expect_issue("t1_c4", 0, 0);

    // 2: younger ready entry bypasses an older waiting one
    send(mk(5, 1, 2, 0, 0)); expect_issue("t2_c0", 0, 0); cyc();
    send(mk(6, 0, 0, 0, 0)); expect_issue("t2_c1", 0, 0); cyc();
    idle();                  expect_issue("t2_c2", 1, 6); cyc();
    wb_valid = 1'b1; wb_robid = 6'd2;
`ifdef RS_WB_BYPASS_EN
    expect_issue("t2_wb", 1, 5); cyc();
    idle(); expect_issue("t2_after", 0, 0); cyc();
`else
    expect_issue("t2_wb", 0, 0); cyc();
    idle(); expect_issue("t2_after", 1, 5); cyc();
`endif
    expect_issue("t2_empty", 0, 0);

    // 3: fill to eight with pending sources
    for (int i = 0; i < 8; i++) begin
      send(mk(10 + i, 1, 40, 0, 0));
      #1;
      chk($sformatf("t3_fill_stall_%0d", i), 64'(rs_stall_rs0), 64'(i == 7));
      cyc();
    end
    idle(); #1;
    chk("t3_full_stall", 64'(rs_stall_rs0), 64'(1));
    cyc();
    wb_valid = 1'b1; wb_robid = 6'd40; ex_stall = 1'b1; #1;
    chk("t3_wake_stall", 64'(rs_stall_rs0), 64'(1));
    cyc();
    idle(); expect_issue("t3_first", 1, 10);
    chk("t3_first_stall", 64'(rs_stall_rs0), 64'(1));
    cyc();
    expect_issue("t3_second", 1, 11);
    chk("t3_second_stall", 64'(rs_stall_rs0), 64'(0));
    cyc();
    repeat (6) cyc();
    expect_issue("t3_drained", 0, 0);

    // 4: wakeup in the same cycle as dispatch
    send(mk(20, 0, 0, 1, 9)); wb_valid = 1'b1; wb_robid = 6'd9;
    expect_issue("t4_c0", 0, 0); cyc();
    idle(); expect_issue("t4_c1", 1, 20); cyc();
    expect_issue("t4_c2", 0, 0);

    // 5: execution unit stall holds entries; oldest goes first on release
    ex_stall = 1'b1; send(mk(30, 0, 0, 0, 0)); cyc();
    send(mk(31, 0, 0, 0, 0)); expect_issue("t5_c1", 1, 30); cyc();
    disp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_issue($sformatf("t5_hold%0d", i), 1, 30); cyc();
    end
    ex_stall = 1'b0; expect_issue("t5_rel0", 1, 30); cyc();
    expect_issue("t5_rel1", 1, 31); cyc();
    expect_issue("t5_empty", 0, 0);

    // 6: flush with five entries and a concurrent dispatch
    ex_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin send(mk(60 + i, 0, 0, 0, 0)); cyc(); end
    ex_stall = 1'b0; flush = 1'b1; send(mk(59, 0, 0, 0, 0)); #1;
    chk("t6_flush_issue_valid", 64'(issue_valid_rs2), 64'(0));
    cyc();
    idle(); #1;
    chk("t6_post_issue_valid", 64'(issue_valid_rs2), 64'(0));
    chk("t6_post_stall", 64'(rs_stall_rs0), 64'(0));
    send(mk(58, 0, 0, 0, 0)); cyc();
    idle(); expect_issue("t6_reuse", 1, 58); cyc();
    expect_issue("t6_empty", 0, 0);

    // async reset in the middle of an issue
    send(mk(50, 0, 0, 0, 0)); cyc();
    idle(); expect_issue("rst_pre", 1, 50);
    reset = 1'b0; #1;
    chk("rst_issue_valid", 64'(issue_valid_rs2), 64'(0));
    chk("rst_stall", 64'(rs_stall_rs0), 64'(0));
    chk("rst_issue_rs2", 64'(issue_rs2), 64'(0));
    cyc();
    reset = 1'b1; cyc();
    expect_issue("rst_after", 0, 0);

    // random traffic, dispatch only when the previous cycle allowed it
    may_disp = 1'b1;
    rid = 100;
    for (int c = 0; c < 3000; c++) begin
      flush    = ($urandom_range(63) == 0);
      ex_stall = ($urandom_range(3) == 0);
      wb_valid = 1'($urandom_range(1));
      wb_robid = t_rob_id'($urandom_range(15));
      if (may_disp && $urandom_range(3) != 0) begin
        send(mk(rid, 1'($urandom_range(1)), $urandom_range(15),
                1'($urandom_range(1)), $urandom_range(15)));
        rid++;
      end else begin
        disp_valid = 1'b0;
      end
      #1;
      may_disp = !rs_stall_rs0;
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
